// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the prefetching IF stage
//
// Purpose : fetch queue entry type, default bubble instruction and a PC
//           alignment helper used by stage_if_prefetch and fetch_fifo.
// Ports   : none (package).
package if_pkg;

  // Instruction presented to ID when no real entry is available.
  localparam logic [31:0] DEFAULT_BUBBLE = 32'h0000_0000;

  // One prefetch queue slot: the instruction word and the PC it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Redirect targets are word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_if_prefetch_if.sv
// rtl/stage_if_prefetch_if.sv - IF stage bus: imem port, ID handshake, redirect
//
// Purpose : bundles the instruction-memory, IF/ID and redirect signals.
// Ports   : master = fetch stage (drives imem_req/instr_addr and the ID
//           outputs); slave = environment (drives br_take, pc_res,
//           stall_IF, instr_from_mem).
interface stage_if_prefetch_if #(
  parameter int ADDR_W = 14
) ();

  logic              br_take;
  logic [31:0]       pc_res;
  logic              stall_IF;
  logic [31:0]       instr_from_mem;
  logic              imem_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              if_valid;
  logic [31:0]       pc_fromIF;
  logic [31:0]       pc4_fromIF;
  logic [31:0]       instr;

  modport master (
    input  br_take, pc_res, stall_IF, instr_from_mem,
    output imem_req, instr_addr, if_valid, pc_fromIF, pc4_fromIF, instr
  );

  modport slave (
    output br_take, pc_res, stall_IF, instr_from_mem,
    input  imem_req, instr_addr, if_valid, pc_fromIF, pc4_fromIF, instr
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry prefetch queue with synchronous flush
//
// Purpose : circular buffer of fetch entries; DEPTH need not be a power of two.
// Ports   : clk, rst_n (async, active-low); push/din write the tail;
//           pop advances the head shown on dout; flush empties the queue
//           on the next edge and overrides push/pop; count = occupancy.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           din,
  output entry_t           dout,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap explicitly at DEPTH-1 so odd depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && count == CNT_W'(DEPTH)));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && count == '0));

endmodule

// File: rtl/stage_if_prefetch.sv
// rtl/stage_if_prefetch.sv - instruction fetch stage with decoupling prefetch queue
//
// Purpose : issues sequential reads to synchronous instruction memory,
//           buffers up to DEPTH returned instructions with their PCs and
//           presents them to ID under stall_IF; br_take flushes the queue
//           and drops any in-flight response.
// Ports   : clk; rst_n (async, active-low); bus (master modport):
//           br_take/pc_res redirect, stall_IF from ID, instr_from_mem read
//           data (one cycle after imem_req), imem_req/instr_addr request,
//           if_valid/pc_fromIF/pc4_fromIF/instr toward ID.
module stage_if_prefetch
  import if_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = DEFAULT_BUBBLE
) (
  input logic                 clk,
  input logic                 rst_n,
  stage_if_prefetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic             resp_valid;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             have_entry;
  logic             push;
  logic             pop;
  logic             issue;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W:0]   credit_limit;

  assign have_entry = (count != '0);
  assign pop        = have_entry & ~bus.stall_IF & ~bus.br_take;
  assign push       = resp_valid & ~bus.br_take;
  assign push_entry = '{pc: resp_pc, instr: bus.instr_from_mem};

  // Credit check: slots already committed (queued + in flight) minus the
  // slot freed by this cycle's pop must leave room for one more response.
  // Written as occupancy < DEPTH + pop to stay unsigned.
  assign occupancy    = {1'b0, count} + {{CNT_W{1'b0}}, resp_valid};
  assign credit_limit = (CNT_W + 1)'(DEPTH) + {{CNT_W{1'b0}}, pop};

  // rst_n gates the request so imem_req is low throughout reset.
  assign issue = rst_n & ~bus.br_take & (occupancy < credit_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= '0;
      resp_valid <= 1'b0;
    end else if (bus.br_take) begin
      fetch_pc   <= word_align(bus.pc_res);
      resp_valid <= 1'b0;
    end else if (issue) begin
      resp_pc    <= fetch_pc;
      fetch_pc   <= fetch_pc + 32'd4;
      resp_valid <= 1'b1;
    end else begin
      resp_valid <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.br_take),
    .din   (push_entry),
    .dout  (head),
    .count (count)
  );

  assign bus.imem_req   = issue;
  assign bus.instr_addr = fetch_pc[ADDR_W+1:2];
  assign bus.if_valid   = have_entry;
  assign bus.pc_fromIF  = have_entry ? head.pc : 32'd0;
  assign bus.pc4_fromIF = have_entry ? head.pc + 32'd4 : 32'd0;
  assign bus.instr      = have_entry ? head.instr : BUBBLE;

endmodule

// File: tb/tb_stage_if_prefetch.sv
// tb/tb_stage_if_prefetch.sv - self-checking bench for stage_if_prefetch
module tb_stage_if_prefetch;
  import if_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  stage_if_prefetch_if #(.ADDR_W(14)) bus_a ();
  stage_if_prefetch_if #(.ADDR_W(14)) bus_b ();

  stage_if_prefetch #(
    .ADDR_W(14), .DEPTH(4), .RESET_PC(32'h0000_0000), .BUBBLE(32'h0000_0000)
  ) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(bus_a)
  );

  stage_if_prefetch #(
    .ADDR_W(14), .DEPTH(3), .RESET_PC(32'h0000_2000), .BUBBLE(32'h0000_0013)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(bus_b)
  );

  typedef struct {
    bit          stall;
    bit          br;
    logic [31:0] pc_res;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  bit           sel;
  logic         o_req, o_valid;
  logic [31:0]  o_addr, o_pc, o_pc4, o_instr;
  logic         in_stall, in_br;
  logic [31:0]  in_pcres;
  logic         mem_pend;
  logic [31:0]  mem_addr;

  fetch_entry_t sbq[$];
  logic [31:0]  m_fpc;
  int           pops;

  function automatic logic [31:0] mem_f(input logic [31:0] pc);
    return 32'h1300_0000 | {16'h0, pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit stall, input bit br, input logic [31:0] pcres);
    in_stall = stall; in_br = br; in_pcres = pcres;
    if (sel) begin
      bus_b.stall_IF = stall; bus_b.br_take = br; bus_b.pc_res = pcres;
    end else begin
      bus_a.stall_IF = stall; bus_a.br_take = br; bus_a.pc_res = pcres;
    end
  endtask

  task automatic observe();
    if (sel) begin
      o_req = bus_b.imem_req; o_addr = {18'h0, bus_b.instr_addr};
      o_valid = bus_b.if_valid; o_pc = bus_b.pc_fromIF;
      o_pc4 = bus_b.pc4_fromIF; o_instr = bus_b.instr;
    end else begin
      o_req = bus_a.imem_req; o_addr = {18'h0, bus_a.instr_addr};
      o_valid = bus_a.if_valid; o_pc = bus_a.pc_fromIF;
      o_pc4 = bus_a.pc4_fromIF; o_instr = bus_a.instr;
    end
  endtask

  task automatic sb_reset(input logic [31:0] pc);
    sbq.delete();
    m_fpc = pc;
    mem_pend = 1'b0;
  endtask

  // Expected entries are queued when a request is issued and compared when
  // the DUT hands an entry to ID; a redirect discards everything outstanding.
  task automatic sb_step();
    fetch_entry_t e;
    if (in_br) begin
      sbq.delete();
      m_fpc = {in_pcres[31:2], 2'b00};
    end else begin
      if (o_valid && !in_stall) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_pop", o_pc, 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("sb_pc", o_pc, e.pc);
          chk("sb_pc4", o_pc4, e.pc + 32'd4);
          chk("sb_instr", o_instr, e.instr);
          pops++;
        end
      end
      if (o_req) begin
        chk("sb_addr", o_addr, {18'h0, m_fpc[15:2]});
        sbq.push_back('{pc: m_fpc, instr: mem_f(m_fpc)});
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic half_sample();
    @(negedge clk);
    observe();
  endtask

  task automatic half_finish();
    logic [31:0] d;
    sb_step();
    mem_pend = o_req;
    mem_addr = o_addr;
    @(posedge clk);
    #1;
    d = mem_pend ? mem_f({mem_addr[29:0], 2'b00}) : 32'hDEAD_BEEF;
    if (sel) bus_b.instr_from_mem = d;
    else     bus_a.instr_from_mem = d;
  endtask

  vec_t tv[18];

  function automatic vec_t mkv(input bit s, input bit b, input logic [31:0] pr,
                               input bit rq, input logic [31:0] ad,
                               input bit v, input logic [31:0] pc);
    vec_t r;
    r.stall = s; r.br = b; r.pc_res = pr; r.req = rq; r.addr = ad; r.valid = v; r.pc = pc;
    return r;
  endfunction

  initial begin
    tv[0]  = mkv(0, 0, 0,      1, 32'h00, 0, 32'h000);
    tv[1]  = mkv(0, 0, 0,      1, 32'h01, 0, 32'h000);
    tv[2]  = mkv(0, 0, 0,      1, 32'h02, 1, 32'h000);
    tv[3]  = mkv(0, 0, 0,      1, 32'h03, 1, 32'h004);
    tv[4]  = mkv(1, 0, 0,      1, 32'h04, 1, 32'h008);
    tv[5]  = mkv(1, 0, 0,      1, 32'h05, 1, 32'h008);
    tv[6]  = mkv(1, 0, 0,      0, 32'h06, 1, 32'h008);
    tv[7]  = mkv(1, 0, 0,      0, 32'h06, 1, 32'h008);
    tv[8]  = mkv(0, 0, 0,      1, 32'h06, 1, 32'h008);
    tv[9]  = mkv(0, 0, 0,      1, 32'h07, 1, 32'h00C);
    tv[10] = mkv(0, 1, 32'h103, 0, 32'h08, 1, 32'h010);
    tv[11] = mkv(0, 0, 0,      1, 32'h40, 0, 32'h000);
    tv[12] = mkv(0, 0, 0,      1, 32'h41, 0, 32'h000);
    tv[13] = mkv(0, 0, 0,      1, 32'h42, 1, 32'h100);
    tv[14] = mkv(1, 1, 32'h200, 0, 32'h43, 1, 32'h104);
    tv[15] = mkv(0, 0, 0,      1, 32'h80, 0, 32'h000);
    tv[16] = mkv(0, 0, 0,      1, 32'h81, 0, 32'h000);
    tv[17] = mkv(0, 0, 0,      1, 32'h82, 1, 32'h200);

    bus_a.stall_IF = 0; bus_a.br_take = 0; bus_a.pc_res = 0; bus_a.instr_from_mem = 0;
    bus_b.stall_IF = 0; bus_b.br_take = 0; bus_b.pc_res = 0; bus_b.instr_from_mem = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    pops = 0;
    sel = 1'b0;
    set_in(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // DUT A reset state
    half_sample();
    chk("a_rst_req", {31'h0, o_req}, 32'd0);
    chk("a_rst_valid", {31'h0, o_valid}, 32'd0);
    chk("a_rst_addr", o_addr, 32'h0);
    chk("a_rst_pc", o_pc, 32'h0);
    chk("a_rst_pc4", o_pc4, 32'h0);
    chk("a_rst_instr", o_instr, 32'h0);
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    sb_reset(32'h0);

    // Table: free run, stall/fill/release, redirect with in-flight response,
    // redirect together with stall.
    for (int i = 0; i < 18; i++) begin
      set_in(tv[i].stall, tv[i].br, tv[i].pc_res);
      half_sample();
      chk($sformatf("v%0d_req", i), {31'h0, o_req}, {31'h0, tv[i].req});
      chk($sformatf("v%0d_addr", i), o_addr, tv[i].addr);
      chk($sformatf("v%0d_valid", i), {31'h0, o_valid}, {31'h0, tv[i].valid});
      chk($sformatf("v%0d_pc", i), o_pc, tv[i].valid ? tv[i].pc : 32'h0);
      chk($sformatf("v%0d_pc4", i), o_pc4, tv[i].valid ? tv[i].pc + 32'd4 : 32'h0);
      chk($sformatf("v%0d_instr", i), o_instr, tv[i].valid ? mem_f(tv[i].pc) : 32'h0);
      half_finish();
    end
    set_in(0, 0, 0);
    rst_a = 1'b0;

    // DUT B: DEPTH 3, RESET_PC 0x2000, BUBBLE 0x13
    sel = 1'b1;
    set_in(0, 0, 0);
    half_sample();
    chk("b_rst_addr", o_addr, 32'h800);
    chk("b_rst_instr", o_instr, 32'h13);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    sb_reset(32'h2000);
    set_in(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      half_sample();
      half_finish();
    end
    half_sample();
    chk("b_full_req", {31'h0, o_req}, 32'd0);
    chk("b_full_valid", {31'h0, o_valid}, 32'd1);
    chk("b_full_pc", o_pc, 32'h2000);
    half_finish();

    // Asynchronous reset in the middle of the high phase
    #2;
    rst_b = 1'b0;
    #1;
    observe();
    chk("b_async_req", {31'h0, o_req}, 32'd0);
    chk("b_async_valid", {31'h0, o_valid}, 32'd0);
    chk("b_async_pc", o_pc, 32'h0);
    chk("b_async_pc4", o_pc4, 32'h0);
    chk("b_async_instr", o_instr, 32'h13);
    chk("b_async_addr", o_addr, 32'h800);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    sb_reset(32'h2000);
    set_in(0, 0, 0);
    half_sample();
    chk("b_c0_req", {31'h0, o_req}, 32'd1);
    chk("b_c0_addr", o_addr, 32'h800);
    chk("b_c0_valid", {31'h0, o_valid}, 32'd0);
    half_finish();
    half_sample();
    chk("b_c1_valid", {31'h0, o_valid}, 32'd0);
    half_finish();
    half_sample();
    chk("b_c2_valid", {31'h0, o_valid}, 32'd1);
    chk("b_c2_pc", o_pc, 32'h2000);
    half_finish();

    // Random stall traffic on the odd-depth queue
    pops = 0;
    for (int i = 0; i < 1000; i++) begin
      set_in(bit'($urandom_range(0, 1)), 0, 0);
      half_sample();
      half_finish();
    end
    chk("b_progress", {31'h0, pops >= 300}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_if_prefetch.md
# stage_if_prefetch

Parametrised instruction-fetch stage with a decoupling prefetch queue: it issues sequential reads to the synchronous instruction memory, buffers up to DEPTH returned instructions with their PCs, and presents them to ID under a stall handshake. Branch redirects flush the queue and discard any in-flight memory response. It replaces the single-entry IF stage between instruction memory and the IF/ID boundary.

## Interface
- ADDR_W, 14: instruction memory word-address width; instr_addr = fetch_pc[ADDR_W+1:2].
- DEPTH, 4: prefetch queue entries, ≥2, need not be a power of two.
- RESET_PC, 32'h0000_0000: fetch PC after reset, word aligned.
- BUBBLE, 32'h0000_0000: instruction driven when no valid entry is presented.

- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- br_take  in  1  redirect from EX, valid this cycle.
- pc_res  in  32  redirect target; bits [1:0] ignored (forced 0).
- stall_IF  in  1  ID cannot accept this cycle.
- instr_from_mem  in  32  memory read data, valid the cycle after imem_req.
- imem_req  out  1  read request to instruction memory this cycle.
- instr_addr  out  ADDR_W  word address of the request.
- if_valid  out  1  presented entry is real.
- pc_fromIF  out  32  PC of presented instruction.
- pc4_fromIF  out  32  pc_fromIF + 4.
- instr  out  32  presented instruction.

## Operation
- State: fetch_pc, resp_valid, resp_pc, queue (entries {pc, instr}, rd/wr pointers wrapping at DEPTH, count 0..DEPTH).
- pop = if_valid & !stall_IF & !br_take.
- Issue: imem_req = !br_take & (count + resp_valid − pop < DEPTH). On issue, resp_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (32-bit wrap), resp_valid ← 1; else resp_valid ← 0. imem_req depends combinationally on stall_IF; this is intended.
- instr_addr = fetch_pc[ADDR_W+1:2] always, even when imem_req is 0.
- Response: when resp_valid, push {resp_pc, instr_from_mem}. No bypass: a pushed entry becomes visible the following cycle.
- Present: count > 0 gives if_valid = 1, with pc_fromIF, pc4_fromIF, instr taken from the head. count = 0 gives if_valid = 0, pc_fromIF = 0, pc4_fromIF = 0, instr = BUBBLE.
- Push and pop in the same cycle: count unchanged. The credit rule guarantees no push when full and no pop when empty. An overflow is an assertion failure.
- br_take has priority over everything:
  - count ← 0; pointers ← 0.
  - resp_valid ← 0, so the in-flight response is dropped.
  - fetch_pc ← {pc_res[31:2], 2'b00}.
  - No issue and no pop that cycle.
- br_take while stall_IF is high: flush still occurs.
- Reset (rst_n low, any time, asynchronous):
  - fetch_pc = RESET_PC; count = 0; pointers = 0; resp_valid = 0.
  - Outputs: imem_req = 0, if_valid = 0, pc_fromIF = 0, pc4_fromIF = 0, instr = BUBBLE, instr_addr = RESET_PC[ADDR_W+1:2].

## Timing
- Cycle 0 after rst_n deasserts: imem_req = 1, address RESET_PC.
- Cycle 1: response pushed.
- Cycle 2: if_valid = 1 with pc = RESET_PC.
- Fetch-to-present latency: 2 cycles. Branch penalty: redirect cycle + 3 cycles to the first valid target instruction.
- Steady-state throughput is 1 instruction per cycle with no stalls, for DEPTH ≥ 2.
- During stall_IF the outputs hold the head entry unchanged. The queue fills to DEPTH, then imem_req drops. When the stall releases, requests restart in the same cycle.

## Structure
- Package if_pkg:
  - localparam BUBBLE default.
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
- Sub-module fetch_fifo, parametrised on DEPTH and the entry type:
  - ports push, pop, flush, din, dout, count.
  - synchronous flush; asynchronous active-low reset.
- The top level holds the fetch PC, response tracking, credit logic and output muxing.

## Test plan
- Reset then free run, stall_IF = 0, memory returns addr×4: instr_addr 0,1,2,…. if_valid rises 2 cycles after release; pc_fromIF 0,4,8 on consecutive cycles; pc4_fromIF = pc + 4.
- stall_IF held for 10 cycles, DEPTH = 4: outputs frozen on the head. Exactly 4 entries are buffered, then imem_req = 0. On release, pcs continue with no gap or duplicate.
- br_take with pc_res = 0x103 while one response is in flight and 3 entries are queued: the next cycle has if_valid = 0 and instr = BUBBLE. The in-flight data never appears. The next request is to word 0x40; the first valid pc is 0x100, 3 cycles after the redirect.
- br_take and stall_IF in the same cycle: the flush wins. The queue empties and no pop is counted.
- rst_n asserted mid-stream with the queue full: all outputs take their reset values immediately, without waiting for a clock edge. Restart fetches from RESET_PC = 0x2000.
- DEPTH = 3 (not a power of two) under random stall_IF for 1000 cycles: PCs are strictly sequential. No overflow or underflow assertion fires.
